axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave_if.sv | 64 ++++++
 rtl/axi_mem_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slave_if.sv
// AXI_BUS: single-clock AXI4 bus bundle with Master/Slave modports.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-beat AXI4 slave backed by a DEPTH x 64-bit register file.
// Optional macro AXI_MEM_SLAVE_ERR_RESP_EN: SLVERR on out-of-range or len != 0
// (no write, read data zero); otherwise the word index wraps modulo DEPTH.
module axi_mem_slave #(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter logic [63:0] BASE_ADDR      = 64'h9000_0000,
  parameter int unsigned DEPTH          = 32
) (
  input logic   clk_i,
  input logic   rst_ni,
  AXI_BUS.Slave axi_slave_port
);
  localparam int unsigned AW    = AXI_ADDR_WIDTH;
  localparam int unsigned WW    = AW - 3;
  localparam int unsigned STRB  = AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // Address decode for both request channels.
  logic [AW-1:0]    aw_off, ar_off;
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_err, ar_err;
  logic             unused_ok;

  assign aw_off = axi_slave_port.aw_addr - AW'(BASE_ADDR);
  assign ar_off = axi_slave_port.ar_addr - AW'(BASE_ADDR);
  assign aw_idx = IDX_W'(aw_off[AW-1:3] % WW'(DEPTH));
  assign ar_idx = IDX_W'(ar_off[AW-1:3] % WW'(DEPTH));

`ifdef AXI_MEM_SLAVE_ERR_RESP_EN
  assign aw_err = (aw_off[AW-1:3] >= WW'(DEPTH)) || (axi_slave_port.aw_len != '0);
  assign ar_err = (ar_off[AW-1:3] >= WW'(DEPTH)) || (axi_slave_port.ar_len != '0);
  assign unused_ok = ^{aw_off[2:0], ar_off[2:0], axi_slave_port.aw_size, axi_slave_port.aw_burst,
                       axi_slave_port.aw_user, axi_slave_port.w_user, axi_slave_port.ar_size,
                       axi_slave_port.ar_burst, axi_slave_port.ar_user};
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  assign unused_ok = ^{aw_off[2:0], ar_off[2:0], axi_slave_port.aw_size, axi_slave_port.aw_burst,
                       axi_slave_port.aw_user, axi_slave_port.w_user, axi_slave_port.ar_size,
                       axi_slave_port.ar_burst, axi_slave_port.ar_user, axi_slave_port.ar_len};
`endif

  // ---------------- write path ----------------
  w_state_e                w_state_q, w_state_d;
  logic [IDX_W-1:0]        aw_idx_q;
  logic [AXI_ID_WIDTH-1:0] aw_id_q;
  logic                    aw_multi_q, aw_err_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB-1:0]         w_strb_q;
  logic                    w_last_q;
  logic                    drain_q, drain_d;
  logic                    aw_rdy, w_rdy, aw_hs, w_hs, commit;
  logic [IDX_W-1:0]        c_idx;
  logic                    c_err, use_live;
  logic [AXI_DATA_WIDTH-1:0] c_data;
  logic [STRB-1:0]         c_strb;

  assign aw_rdy = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
  assign w_rdy  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
  assign aw_hs  = axi_slave_port.aw_valid && aw_rdy;
  assign w_hs   = axi_slave_port.w_valid && w_rdy;

  // Commit operands: live channel values when the handshake lands on the commit edge.
  // drain_q marks that the first beat is already held and later beats are discarded.
  assign use_live = w_hs && !drain_q;
  assign c_idx    = aw_hs ? aw_idx : aw_idx_q;
  assign c_err    = aw_hs ? aw_err : aw_err_q;
  assign c_data   = use_live ? axi_slave_port.w_data : w_data_q;
  assign c_strb   = use_live ? axi_slave_port.w_strb : w_strb_q;

  // Write FSM next state; commit pulses on the edge entering W_RESP.
  always_comb begin
    w_state_d = w_state_q;
    drain_d   = drain_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          if ((axi_slave_port.aw_len == '0) || axi_slave_port.w_last) begin
            w_state_d = W_RESP;
            commit    = 1'b1;
          end else begin
            w_state_d = W_HAVE_AW;
            drain_d   = 1'b1;
          end
        end else if (aw_hs) begin
          w_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          if (!aw_multi_q || axi_slave_port.w_last) begin
            w_state_d = W_RESP;
            commit    = 1'b1;
            drain_d   = 1'b0;
          end else begin
            drain_d   = 1'b1;
          end
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          if ((axi_slave_port.aw_len == '0) || w_last_q) begin
            w_state_d = W_RESP;
            commit    = 1'b1;
          end else begin
            w_state_d = W_HAVE_AW;
            drain_d   = 1'b1;
          end
        end
      end
      W_RESP: begin
        drain_d = 1'b0;
        if (axi_slave_port.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state and captured AW/W fields.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      drain_q    <= 1'b0;
      aw_idx_q   <= '0;
      aw_id_q    <= '0;
      aw_multi_q <= 1'b0;
      aw_err_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      w_last_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      drain_q   <= drain_d;
      if (aw_hs) begin
        aw_idx_q   <= aw_idx;
        aw_id_q    <= axi_slave_port.aw_id;
        aw_multi_q <= (axi_slave_port.aw_len != '0);
        aw_err_q   <= aw_err;
      end
      if (use_live) begin
        w_data_q <= axi_slave_port.w_data;
        w_strb_q <= axi_slave_port.w_strb;
        w_last_q <= axi_slave_port.w_last;
      end
    end
  end

  // Memory array: cleared on reset, byte-enabled write on commit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && !c_err) begin
      for (int unsigned b = 0; b < STRB; b++) begin
        if (c_strb[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  assign axi_slave_port.aw_ready = aw_rdy;
  assign axi_slave_port.w_ready  = w_rdy;
  assign axi_slave_port.b_valid  = (w_state_q == W_RESP);
  assign axi_slave_port.b_id     = aw_id_q;
  assign axi_slave_port.b_resp   = aw_err_q ? 2'b10 : 2'b00;
  assign axi_slave_port.b_user   = '0;

  // ---------------- read path ----------------
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic                      r_err_q;
  logic                      ar_hs;

  assign ar_hs = axi_slave_port.ar_valid && (r_state_q == R_IDLE);

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (axi_slave_port.r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state; data sampled on the AR edge (pre-write value on a same-edge commit).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_id_q    <= '0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q   <= axi_slave_port.ar_id;
        r_err_q  <= ar_err;
        r_data_q <= ar_err ? '0 : mem[ar_idx];
      end
    end
  end

  assign axi_slave_port.ar_ready = (r_state_q == R_IDLE);
  assign axi_slave_port.r_valid  = (r_state_q == R_DATA);
  assign axi_slave_port.r_last   = (r_state_q == R_DATA);
  assign axi_slave_port.r_data   = r_data_q;
  assign axi_slave_port.r_id     = r_id_q;
  assign axi_slave_port.r_resp   = r_err_q ? 2'b10 : 2'b00;
  assign axi_slave_port.r_user   = '0;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: vector table plus multi-cycle sequences.
module tb_axi_mem_slave;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  AXI_BUS #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)
  ) bus ();

  axi_mem_slave #(
    .AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(10),
    .BASE_ADDR(64'h9000_0000), .DEPTH(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_slave_port(bus)
  );

`ifdef AXI_MEM_SLAVE_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          do_wr;
    logic [63:0] wa;
    logic [63:0] wd;
    logic [7:0]  ws;
    logic [1:0]  bresp;
    logic [63:0] ra;
    logic [63:0] rdat;
    logic [1:0]  rresp;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
    bus.aw_size = 3'd3; bus.aw_burst = 2'b01; bus.aw_user = '0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b1; bus.w_user = '0;
    bus.b_ready = 1'b1;
    bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
    bus.ar_size = 3'd3; bus.ar_burst = 2'b01; bus.ar_user = '0;
    bus.r_ready = 1'b1;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                    input logic [9:0] id, input logic [1:0] exp_resp, input string name);
    bus.aw_valid = 1'b1; bus.aw_addr = addr; bus.aw_id = id; bus.aw_len = '0;
    bus.w_valid = 1'b1; bus.w_data = data; bus.w_strb = strb; bus.w_last = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk({name, " b_valid"}, 64'(bus.b_valid), 64'd1);
    chk({name, " b_id"}, 64'(bus.b_id), 64'(id));
    chk({name, " b_resp"}, 64'(bus.b_resp), 64'(exp_resp));
    tick();
    chk({name, " b_valid drop"}, 64'(bus.b_valid), 64'd0);
  endtask

  task automatic rd(input logic [63:0] addr, input logic [7:0] len, input logic [9:0] id,
                    input logic [63:0] exp_data, input logic [1:0] exp_resp, input string name);
    bus.ar_valid = 1'b1; bus.ar_addr = addr; bus.ar_id = id; bus.ar_len = len;
    tick();
    bus.ar_valid = 1'b0; bus.ar_len = '0;
    chk({name, " r_valid"}, 64'(bus.r_valid), 64'd1);
    chk({name, " r_data"}, bus.r_data, exp_data);
    chk({name, " r_resp"}, 64'(bus.r_resp), 64'(exp_resp));
    chk({name, " r_id"}, 64'(bus.r_id), 64'(id));
    chk({name, " r_last"}, 64'(bus.r_last), 64'd1);
    tick();
    chk({name, " r_valid drop"}, 64'(bus.r_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 64'h9000_0000, 64'hdead_beef_1234_5678, 8'hFF, OKAY,
                64'h9000_0000, 64'hdead_beef_1234_5678, OKAY};
    vecs[1] = '{1'b1, 64'h9000_0018, 64'h0123_4567_89AB_CDEF, 8'hF0, OKAY,
                64'h9000_0018, 64'h0123_4567_0000_0000, OKAY};
    vecs[2] = '{1'b1, 64'h9000_001C, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, OKAY,
                64'h9000_0018, 64'h0123_4567_0000_00FF, OKAY};
    vecs[3] = '{1'b1, 64'h9000_00F8, 64'h5555_AAAA_5555_AAAA, 8'hFF, OKAY,
                64'h9000_00F8, 64'h5555_AAAA_5555_AAAA, OKAY};
    vecs[4] = '{1'b1, 64'h9000_0100, 64'h7777_7777_7777_7777, 8'hFF, ERR_EN ? SLVERR : OKAY,
                64'h9000_0000, ERR_EN ? 64'hdead_beef_1234_5678 : 64'h7777_7777_7777_7777, OKAY};
    vecs[5] = '{1'b0, 64'h0, 64'h0, 8'h00, OKAY,
                64'h9000_0118, ERR_EN ? 64'h0 : 64'h0123_4567_0000_00FF, ERR_EN ? SLVERR : OKAY};
    vecs[6] = '{1'b0, 64'h0, 64'h0, 8'h00, OKAY,
                64'h8FFF_FFF8, ERR_EN ? 64'h0 : 64'h5555_AAAA_5555_AAAA, ERR_EN ? SLVERR : OKAY};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst aw_ready", 64'(bus.aw_ready), 64'd1);
    chk("rst w_ready", 64'(bus.w_ready), 64'd1);
    chk("rst ar_ready", 64'(bus.ar_ready), 64'd1);
    chk("rst b_valid", 64'(bus.b_valid), 64'd0);
    chk("rst r_valid", 64'(bus.r_valid), 64'd0);
    chk("rst r_data", bus.r_data, 64'd0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_wr)
        wr(vecs[i].wa, vecs[i].wd, vecs[i].ws, 10'(i + 1), vecs[i].bresp, $sformatf("vec%0d wr", i));
      rd(vecs[i].ra, 8'd0, 10'(i + 16), vecs[i].rdat, vecs[i].rresp, $sformatf("vec%0d rd", i));
    end

    // W three cycles ahead of AW, partial strobe.
    bus.w_valid = 1'b1; bus.w_data = 64'h1111_2222_3333_4444; bus.w_strb = 8'h0F; bus.w_last = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("early_w w_ready", 64'(bus.w_ready), 64'd0);
      chk("early_w aw_ready", 64'(bus.aw_ready), 64'd1);
      chk("early_w b_valid", 64'(bus.b_valid), 64'd0);
      tick();
    end
    bus.aw_valid = 1'b1; bus.aw_addr = 64'h9000_0008; bus.aw_id = 10'd7; bus.aw_len = '0;
    tick();
    bus.aw_valid = 1'b0;
    chk("early_w b_valid", 64'(bus.b_valid), 64'd1);
    chk("early_w b_id", 64'(bus.b_id), 64'd7);
    chk("early_w b_resp", 64'(bus.b_resp), 64'(OKAY));
    tick();
    rd(64'h9000_0008, 8'd0, 10'd8, 64'h0000_0000_3333_4444, OKAY, "early_w rd");

    // Backpressure on B for five cycles.
    bus.b_ready = 1'b0;
    bus.aw_valid = 1'b1; bus.aw_addr = 64'h9000_0020; bus.aw_id = 10'd9;
    bus.w_valid = 1'b1; bus.w_data = 64'h0000_0000_0000_0C0C; bus.w_strb = 8'hFF; bus.w_last = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bstall b_valid", 64'(bus.b_valid), 64'd1);
      chk("bstall aw_ready", 64'(bus.aw_ready), 64'd0);
      chk("bstall w_ready", 64'(bus.w_ready), 64'd0);
      tick();
    end
    chk("bstall b_id", 64'(bus.b_id), 64'd9);
    bus.b_ready = 1'b1;
    tick();
    chk("bstall b_valid drop", 64'(bus.b_valid), 64'd0);
    rd(64'h9000_0020, 8'd0, 10'd10, 64'h0000_0000_0000_0C0C, OKAY, "bstall rd");

    // Read and write to the same word on the same edge: read sees old value.
    bus.aw_valid = 1'b1; bus.aw_addr = 64'h9000_0010; bus.aw_id = 10'd3;
    bus.w_valid = 1'b1; bus.w_data = 64'hAA; bus.w_strb = 8'hFF; bus.w_last = 1'b1;
    bus.ar_valid = 1'b1; bus.ar_addr = 64'h9000_0010; bus.ar_id = 10'd4;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    chk("rw_same r_valid", 64'(bus.r_valid), 64'd1);
    chk("rw_same r_data old", bus.r_data, 64'd0);
    chk("rw_same b_valid", 64'(bus.b_valid), 64'd1);
    tick();
    rd(64'h9000_0010, 8'd0, 10'd5, 64'hAA, OKAY, "rw_same rd new");

    // Burst write: first beat kept, remaining beats drained.
    bus.aw_valid = 1'b1; bus.aw_addr = 64'h9000_0028; bus.aw_id = 10'h11; bus.aw_len = 8'd2;
    bus.w_valid = 1'b1; bus.w_data = 64'hBEEF; bus.w_strb = 8'hFF; bus.w_last = 1'b0;
    tick();
    bus.aw_valid = 1'b0; bus.aw_len = '0; bus.w_data = 64'h1111;
    chk("burst b_valid beat0", 64'(bus.b_valid), 64'd0);
    chk("burst w_ready beat0", 64'(bus.w_ready), 64'd1);
    chk("burst aw_ready beat0", 64'(bus.aw_ready), 64'd0);
    tick();
    chk("burst b_valid beat1", 64'(bus.b_valid), 64'd0);
    chk("burst w_ready beat1", 64'(bus.w_ready), 64'd1);
    bus.w_data = 64'h2222; bus.w_last = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    chk("burst b_valid", 64'(bus.b_valid), 64'd1);
    chk("burst b_resp", 64'(bus.b_resp), 64'(ERR_EN ? SLVERR : OKAY));
    chk("burst b_id", 64'(bus.b_id), 64'h11);
    tick();
    rd(64'h9000_0028, 8'd0, 10'd12, ERR_EN ? 64'h0 : 64'hBEEF, OKAY, "burst rd");
    rd(64'h9000_0028, 8'd3, 10'd13, ERR_EN ? 64'h0 : 64'hBEEF, ERR_EN ? SLVERR : OKAY, "arlen rd");

    // Reset while holding an AW without W.
    bus.aw_valid = 1'b1; bus.aw_addr = 64'h9000_0030; bus.aw_id = 10'd5;
    tick();
    bus.aw_valid = 1'b0;
    chk("rstmid w_ready", 64'(bus.w_ready), 64'd1);
    chk("rstmid aw_ready", 64'(bus.aw_ready), 64'd0);
    rst_n = 1'b0;
    bus.w_valid = 1'b1; bus.w_data = 64'hFFFF; bus.w_strb = 8'hFF;
    tick();
    tick();
    bus.w_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rstmid b_valid", 64'(bus.b_valid), 64'd0);
      chk("rstmid aw_ready", 64'(bus.aw_ready), 64'd1);
      chk("rstmid w_ready", 64'(bus.w_ready), 64'd1);
      chk("rstmid ar_ready", 64'(bus.ar_ready), 64'd1);
      tick();
    end
    for (int w = 0; w < 32; w++)
      rd(64'h9000_0000 + 64'(w * 8), 8'd0, 10'(w), 64'd0, OKAY, $sformatf("rstmid word%0d", w));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
